// File: rtl/ajw_div_pkg.sv
// ajw_div_pkg
//   Shared types and constants for the RV32M iterative divider.
//   div_op_e     : DIV=0, DIVU=1, REM=2, REMU=3
//   div_state_e  : IDLE, CALC, DONE
//   DIV_BY_ZERO_Q: quotient returned for a zero divisor
//   INT_MIN      : most negative 32-bit value (signed-overflow dividend/quotient)
package ajw_div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    function automatic logic is_signed_op(input div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_rem_op(input div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/ajw_div_unit_addsub.sv
// ajw_addsub_unit
//   Shared execute-stage adder: sum = op_x + op_y + cin, with carry-out.
//   The divider drives op_y = ~divisor, cin = 1 to form a trial subtraction.
//   Ports:
//     op_x, op_y : W-bit operands
//     cin        : carry in
//     sum        : W-bit sum
//     cout       : carry out (1 = no borrow when used as subtractor)
module ajw_addsub_unit #(
    parameter int W = 32
) (
    input  logic [W-1:0] op_x,
    input  logic [W-1:0] op_y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, op_x} + {1'b0, op_y} + {{W{1'b0}}, cin};

endmodule

// File: rtl/ajw_div_unit.sv
// ajw_div_unit
//   Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   One quotient bit per cycle: accept edge + XLEN CALC edges, then the
//   result is held in DONE until the writeback side takes it.
//   Optional build macro: AJW_DIV_FAST_PATH_EN -- divide-by-zero and signed
//   overflow go straight from IDLE to DONE on the accepting edge.
//   Ports:
//     clk_i, rst_ni        : clock, asynchronous active-low reset
//     valid_i / ready_o    : issue handshake (ready_o only in IDLE)
//     op_i                 : operation (div_op_e)
//     dividend_i/divisor_i : rs1 / rs2
//     flush_i              : abort in-flight operation, drop any result
//     valid_o / ready_i    : writeback handshake
//     result_o             : quotient (DIV/DIVU) or remainder (REM/REMU)
//     busy_o               : stall request, high in CALC and DONE
module ajw_div_unit
    import ajw_div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  div_op_e         op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] v);
        return ~v + 1'b1;
    endfunction

    div_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic            rem_sel;
    logic            q_neg;
    logic            r_neg;
    logic            special;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] special_val;
    logic [XLEN-1:0] result;
    logic            valid;

    // Operand conditioning at acceptance
    logic            accept;
    logic            sgn_op;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] spec_val_in;

    assign accept   = valid_i && (state == IDLE) && !flush_i;
    assign sgn_op   = is_signed_op(op_i);
    assign a_neg    = sgn_op && dividend_i[XLEN-1];
    assign b_neg    = sgn_op && divisor_i[XLEN-1];
    assign div_zero = (divisor_i == '0);
    assign ovf      = sgn_op && (dividend_i == INT_MIN) && (divisor_i == '1);

    always_comb begin
        spec_val_in = '0;
        if (div_zero)
            spec_val_in = is_rem_op(op_i) ? dividend_i : DIV_BY_ZERO_Q;
        else if (!is_rem_op(op_i))
            spec_val_in = INT_MIN;
    end

    // Trial subtraction step
    logic [XLEN-1:0] op_x;
    logic [XLEN-1:0] sum;
    logic            cout;
    logic            take;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;
    logic [XLEN-1:0] final_val;

    assign op_x = {rem[XLEN-2:0], quo[XLEN-1]};

    ajw_addsub_unit #(.W(XLEN)) u_addsub (
        .op_x (op_x),
        .op_y (~dvs),
        .cin  (1'b1),
        .sum  (sum),
        .cout (cout)
    );

    // The bit shifted out of rem is the 33rd bit of the partial remainder;
    // if it is set the partial remainder already exceeds any 32-bit divisor,
    // so subtract regardless of cout (sum is still exact modulo 2**XLEN).
    // This only matters for DIVU/REMU with divisors >= 2**(XLEN-1).
    assign take    = cout || rem[XLEN-1];
    assign rem_nxt = take ? sum : op_x;
    assign quo_nxt = {quo[XLEN-2:0], take};

    always_comb begin
        if (special)
            final_val = special_val;
        else if (rem_sel)
            final_val = r_neg ? neg2c(rem_nxt) : rem_nxt;
        else
            final_val = q_neg ? neg2c(quo_nxt) : quo_nxt;
    end

    // Control and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_sel     <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            special     <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            special_val <= '0;
            result      <= '0;
            valid       <= 1'b0;
        end else if (flush_i) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        rem_sel     <= is_rem_op(op_i);
                        q_neg       <= a_neg ^ b_neg;
                        r_neg       <= a_neg;
                        special     <= div_zero || ovf;
                        special_val <= spec_val_in;
                        rem         <= '0;
                        quo         <= a_neg ? neg2c(dividend_i) : dividend_i;
                        dvs         <= b_neg ? neg2c(divisor_i) : divisor_i;
`ifdef AJW_DIV_FAST_PATH_EN
                        if (div_zero || ovf) begin
                            state  <= DONE;
                            result <= spec_val_in;
                            valid  <= 1'b1;
                        end else begin
                            state <= CALC;
                            cnt   <= CNT_W'(XLEN - 1);
                        end
`else
                        state <= CALC;
                        cnt   <= CNT_W'(XLEN - 1);
`endif
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    if (cnt == '0) begin
                        state  <= DONE;
                        result <= final_val;
                        valid  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state <= IDLE;
                        valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o  = (state == IDLE);
    assign busy_o   = (state != IDLE);
    assign valid_o  = valid;
    assign result_o = result;

endmodule

// File: tb/tb_ajw_div_unit.sv
// tb_ajw_div_unit
//   Directed self-checking bench for ajw_div_unit: unsigned/signed divide and
//   remainder, zero divisor, signed overflow, backpressure, flush and async reset.
module tb_ajw_div_unit;
    import ajw_div_pkg::*;

`ifdef AJW_DIV_FAST_PATH_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 33;
`endif
    localparam int NORM_LAT = 33;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        ready_out;
    div_op_e     op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    ajw_div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .valid_i    (valid_in),
        .ready_o    (ready_out),
        .op_i       (op),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .flush_i    (flush),
        .valid_o    (valid_out),
        .ready_i    (ready_in),
        .result_o   (result),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at the negedge right after the accepting edge.
    task automatic wait_result(input string tag, input logic [31:0] expv, input int exp_lat);
        int lat = 1;
        while (!valid_out && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result, expv);
    endtask

    task automatic do_op(input string tag, input div_op_e o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expv, input int exp_lat);
        check({tag, "_rdy"}, 32'(ready_out), 32'd1);
        op       = o;
        dividend = a;
        divisor  = b;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        wait_result(tag, expv, exp_lat);
        // ready_in is high here, so the next edge retires the result
        @(posedge clk);
        @(negedge clk);
        check({tag, "_retire"}, 32'(valid_out), 32'd0);
    endtask

    initial begin
        int bad;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        op       = DIVU;
        dividend = '0;
        divisor  = '0;
        flush    = 1'b0;
        ready_in = 1'b1;
        #12;
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_result", result,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("divu_100_7",   DIVU, 32'd100,        32'd7,          32'd14,         NORM_LAT);
        do_op("remu_100_7",   REMU, 32'd100,        32'd7,          32'd2,          NORM_LAT);
        do_op("div_m100_7",   DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  NORM_LAT);
        do_op("rem_m100_7",   REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  NORM_LAT);
        do_op("div_7_m2",     DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  NORM_LAT);
        do_op("rem_7_m2",     REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          NORM_LAT);
        do_op("divu_big",     DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          NORM_LAT);
        do_op("remu_big",     REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          NORM_LAT);
        do_op("div_5_0",      DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  SPEC_LAT);
        do_op("rem_5_0",      REM,  32'd5,          32'd0,          32'd5,          SPEC_LAT);
        do_op("divu_5_0",     DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  SPEC_LAT);
        do_op("div_ovf",      DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  SPEC_LAT);
        do_op("rem_ovf",      REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          SPEC_LAT);
        do_op("divu_intmin",  DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          NORM_LAT);

        // Backpressure: hold the result for 10 cycles while a new request is offered
        ready_in = 1'b0;
        op       = DIVU;
        dividend = 32'd100;
        divisor  = 32'd7;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        wait_result("bp", 32'd14, NORM_LAT);
        dividend = 32'd1000;
        divisor  = 32'd10;
        valid_in = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!(valid_out === 1'b1 && result === 32'd14 && ready_out === 1'b0 && busy === 1'b1))
                bad++;
        end
        check("bp_hold", 32'(bad), 32'd0);
        ready_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid", 32'(valid_out), 32'd0);
        check("bp_release_idle",  32'(busy),      32'd0);
        // valid_in still high: accepted on this edge, not earlier
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        check("bp_accept_busy", 32'(busy), 32'd1);
        wait_result("bp_next", 32'd100, NORM_LAT);
        @(posedge clk);
        @(negedge clk);

        // No acceptance while flush is asserted
        op       = DIVU;
        dividend = 32'd9;
        divisor  = 32'd3;
        valid_in = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        flush    = 1'b0;
        check("flush_no_accept", 32'(busy), 32'd0);

        // Flush in CALC cycle 12
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (11) begin
            @(posedge clk);
            @(negedge clk);
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy",  32'(busy),      32'd0);
        check("flush_ready", 32'(ready_out), 32'd1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_out !== 1'b0) bad++;
            @(posedge clk);
            @(negedge clk);
        end
        check("flush_never_valid", 32'(bad), 32'd0);

        // Async reset mid-CALC; result_o still holds 100 from before
        op       = DIVU;
        dividend = 32'd77;
        divisor  = 32'd5;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready",  32'(ready_out), 32'd1);
        check("arst_valid",  32'(valid_out), 32'd0);
        check("arst_busy",   32'(busy),      32'd0);
        check("arst_result", result,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("post_rst_divu", DIVU, 32'd1000, 32'd10, 32'd100, NORM_LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ajw_div_unit.md
Name: ajw_div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting in the execute stage beside the ALU.
- Feeds the existing ajw_addsub_unit with the trial subtraction each cycle and consumes its sum/carry-out to decide each quotient bit.
- Uses a valid/ready handshake upstream (issue) and downstream (writeback mux), and accepts a pipeline flush.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > XLEN.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  operands and op valid.
- ready_o  out  1  unit can accept; high only in IDLE.
- op_i  in  2  ajw_div_pkg::div_op_e: DIV=0, DIVU=1, REM=2, REMU=3.
- dividend_i  in  XLEN  rs1 value.
- divisor_i  in  XLEN  rs2 value.
- flush_i  in  1  abort any in-flight operation.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- result_o  out  XLEN  quotient for DIV/DIVU, remainder for REM/REMU.
- busy_o  out  1  high in CALC or DONE; used as the pipeline stall request.

Behaviour:
- Reset (async, rst_ni=0): state IDLE, counter 0, all datapath registers 0. Outputs: ready_o=1, valid_o=0, busy_o=0, result_o=0.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC on valid_i&ready_o. Latch op, sign flags, |dividend| and |divisor|. For DIVU/REMU and for non-negative values, latch the raw values. Clear the remainder register; counter=XLEN-1.
  - CALC, each cycle:
    - Shift {rem,quo} left by 1.
    - Drive addsub with opX={rem[XLEN-2:0],quo[XLEN-1]}, opY=~divisor, cin=1.
    - cout=1: rem<=sum and shifted-in quotient bit=1. Otherwise rem<=opX and quotient bit=0.
    - Counter decrements. CALC -> DONE on the cycle the counter is 0, i.e. exactly XLEN CALC cycles.
  - On CALC->DONE, result_o is registered with sign correction (two's-complement negate):
    - Quotient is negated when signs differ (DIV).
    - Remainder takes the sign of the dividend (REM).
  - DONE: valid_o=1, result_o stable. DONE -> IDLE when ready_i=1. valid_o holds with result unchanged while ready_i=0.
- Latency: acceptance edge plus XLEN CALC edges. valid_o rises 33 cycles after the accepting edge. Throughput is 1 operation per 34 cycles minimum.
- ready_o=0 in CALC and DONE. A valid_i seen there is ignored, not queued.
- Special cases must match the RISC-V spec:
  - Divisor 0: quotient=32'hFFFF_FFFF for DIV and DIVU; remainder=dividend for REM and REMU.
  - Signed overflow (DIV/REM, 32'h8000_0000 / 32'hFFFF_FFFF): quotient=32'h8000_0000, remainder=0.
  - Detect both at acceptance and override result_o at the CALC->DONE edge.
- flush_i: in any state, the next edge returns to IDLE, clears valid_o, and discards the result. flush_i has priority over ready_i and valid_i. No operation is accepted on a cycle where flush_i=1.
- Simultaneous DONE&ready_i with valid_i: not accepted that cycle, since ready_o=0. Acceptance is next cycle at the earliest.
- Counter wrap: the counter never decrements below 0. IDLE holds it at 0.

Optional Feature:
- AJW_DIV_FAST_PATH_EN.
- Defined: divisor-zero and signed-overflow cases skip CALC, going IDLE -> DONE on the accepting edge. valid_o is high 1 cycle after acceptance.
- Undefined: these cases take the full XLEN-cycle path, with the result overridden as above.
- Normal divides are identical in both builds.

Decomposition:
- Package ajw_div_pkg:
  - div_op_e enum.
  - div_state_e enum {IDLE, CALC, DONE}.
  - Constants DIV_BY_ZERO_Q=32'hFFFF_FFFF and INT_MIN=32'h8000_0000.
  - Helper function is_signed_op(op).
- Sub-module: one instance of the existing ajw_addsub_unit for the trial subtraction.
- Sign negation is local logic in the divider.

Test Plan:
- DIVU 100/7, ready_i=1: valid_o 33 cycles after accept, result_o=14. Repeat as REMU: result_o=2.
- DIV -100/7 -> result_o=32'hFFFF_FFF2 (-14). REM -100/7 -> result_o=32'hFFFF_FFFE (-2).
- DIV 5/0 -> 32'hFFFF_FFFF; REM 5/0 -> 5. Latency is 33 without the macro and 1 with AJW_DIV_FAST_PATH_EN.
- DIV 32'h8000_0000/32'hFFFF_FFFF -> 32'h8000_0000; REM of the same operands -> 0.
- Backpressure: ready_i held 0 for 10 cycles in DONE. Required: valid_o and result_o stable throughout, ready_o=0, a new valid_i ignored. Accept happens the cycle after ready_i=1.
- Flush at CALC cycle 12 -> IDLE next edge, valid_o never asserts. Async reset pulse mid-CALC -> all outputs at reset values immediately. A following DIVU 1000/10 returns 100.
